prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 94 +++++++++
 tb/tb_prog_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: packs UART bytes big-endian into instruction words and writes
// them to consecutive instruction-memory addresses until a halt word or a full memory.
module prog_loader #(
    parameter int                  NBIT_DATA_LEN = 8,
    parameter int                  len_data      = 32,
    parameter int                  len_addr      = 8,
    parameter logic [len_data-1:0] HALT_WORD     = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     rx_done_tick,
    input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
    output logic [len_addr-1:0]      addr_mem_inst,
    output logic [len_data-1:0]      ins_to_mem,
    output logic                     wr_ram_inst,
    output logic                     busy,
    output logic                     done,
    output logic                     err_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [len_addr-1:0] ADDR_LAST = {len_addr{1'b1}};

    logic [1:0]          state;
    logic [1:0]          byte_cnt;
    logic [len_data-1:0] shift;

    assign busy = (state == S_RECV) || (state == S_WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            shift         <= '0;
            addr_mem_inst <= '0;
            ins_to_mem    <= '0;
            wr_ram_inst   <= 1'b0;
            done          <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            // NOTE: the write strobe defaults low every cycle so it can only last one cycle.
            wr_ram_inst <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RECV;
                        addr_mem_inst <= '0;
                        byte_cnt      <= '0;
                        shift         <= '0;
                        err_overflow  <= 1'b0;
                        done          <= 1'b0;
                    end
                end

                S_RECV, S_WRITE: begin
                    // Bytes keep flowing during WRITE; ins_to_mem is a separate register.
                    if (rx_done_tick) begin
                        shift    <= {shift[len_data-NBIT_DATA_LEN-1:0], rx_data_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            ins_to_mem  <= {shift[len_data-NBIT_DATA_LEN-1:0], rx_data_in};
                            wr_ram_inst <= 1'b1;
                            state       <= S_WRITE;
                        end
                    end

                    // A word cannot complete in WRITE (byte_cnt is 0 there), so this decision wins.
                    if (state == S_WRITE) begin
                        if (ins_to_mem == HALT_WORD) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (addr_mem_inst == ADDR_LAST) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            err_overflow <= 1'b1;
                        end else begin
                            addr_mem_inst <= addr_mem_inst + 1'b1;
                            state         <= S_RECV;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a wide (len_addr=8) and a narrow (len_addr=2) instance share
// the same stimulus; a transaction-level model predicts both every cycle.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data_in = 8'h00;

    logic [7:0]  addr0;
    logic [31:0] ins0;
    logic        wr0, busy0, done0, err0;
    logic [1:0]  addr1;
    logic [31:0] ins1;
    logic        wr1, busy1, done1, err1;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(.len_addr(8)) dut_wide (
        .clk(clk), .reset(reset), .start(start), .rx_done_tick(rx_done_tick),
        .rx_data_in(rx_data_in), .addr_mem_inst(addr0), .ins_to_mem(ins0),
        .wr_ram_inst(wr0), .busy(busy0), .done(done0), .err_overflow(err0)
    );

    prog_loader #(.len_addr(2)) dut_narrow (
        .clk(clk), .reset(reset), .start(start), .rx_done_tick(rx_done_tick),
        .rx_data_in(rx_data_in), .addr_mem_inst(addr1), .ins_to_mem(ins1),
        .wr_ram_inst(wr1), .busy(busy1), .done(done1), .err_overflow(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: mode 0 idle, 1 loading, 2 finished.
    int          m_mode[2];
    int          m_cur[2];
    int          m_cnt[2];
    logic [31:0] m_acc[2];
    bit          m_pend[2];
    logic        e_wr[2];
    logic [31:0] e_data[2];
    logic        e_done[2];
    logic        e_err[2];
    int          max_addr[2] = '{255, 3};

    task automatic model_step(input int i);
        if (reset) begin
            m_mode[i] = 0; m_cur[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_pend[i] = 0;
            e_wr[i] = 0; e_data[i] = 0; e_done[i] = 0; e_err[i] = 0;
        end else if (m_mode[i] != 1) begin
            if (start) begin
                m_mode[i] = 1; m_cur[i] = 0; m_cnt[i] = 0; m_acc[i] = 0; m_pend[i] = 0;
                e_done[i] = 0; e_err[i] = 0;
            end
        end else begin
            if (m_pend[i]) begin
                m_pend[i] = 0;
                e_wr[i] = 0;
                if (e_data[i] == 32'hFFFF_FFFF) begin
                    m_mode[i] = 2; e_done[i] = 1;
                end else if (m_cur[i] == max_addr[i]) begin
                    m_mode[i] = 2; e_done[i] = 1; e_err[i] = 1;
                end else begin
                    m_cur[i] = m_cur[i] + 1;
                end
            end
            if (rx_done_tick) begin
                m_acc[i] = (m_acc[i] << 8) | {24'h0, rx_data_in};
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == 4) begin
                    e_data[i] = m_acc[i]; e_wr[i] = 1; m_pend[i] = 1;
                    m_cnt[i] = 0; m_acc[i] = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Observed write log per instance, pinned against literal lists.
    logic [7:0]  log_a0[$];
    logic [31:0] log_d0[$];
    logic [7:0]  log_a1[$];
    logic [31:0] log_d1[$];

    task automatic cmp_inst(input int i, input logic wr, input logic [7:0] addr,
                            input logic [31:0] data, input logic bsy,
                            input logic dn, input logic er);
        string p;
        p = (i == 0) ? "wide" : "narrow";
        check({p, "_wr"},   {31'h0, wr},  {31'h0, e_wr[i]});
        check({p, "_addr"}, {24'h0, addr}, m_cur[i]);
        check({p, "_busy"}, {31'h0, bsy}, {31'h0, (m_mode[i] == 1)});
        check({p, "_done"}, {31'h0, dn},  {31'h0, e_done[i]});
        check({p, "_err"},  {31'h0, er},  {31'h0, e_err[i]});
        if (e_wr[i]) check({p, "_data"}, data, e_data[i]);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, wr0, addr0, ins0, busy0, done0, err0);
            cmp_inst(1, wr1, {6'h0, addr1}, ins1, busy1, done1, err1);
            if (wr0) begin log_a0.push_back(addr0); log_d0.push_back(ins0); end
            if (wr1) begin log_a1.push_back({6'h0, addr1}); log_d1.push_back(ins1); end
        end
    end

    // Each call consumes exactly one rising edge; inputs change 1 time unit after edges.
    task automatic cyc(input logic s, input logic t, input logic [7:0] d);
        start = s; rx_done_tick = t; rx_data_in = d;
        @(posedge clk); #1;
        start = 1'b0; rx_done_tick = 1'b0; rx_data_in = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 8'h00);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, v[31:24]);
            v = v << 8;
            cyc(0, 0, 8'h00);
        end
    endtask

    task automatic clear_logs();
        log_a0.delete(); log_d0.delete(); log_a1.delete(); log_d1.delete();
    endtask

    task automatic check_log0(input int k, input logic [7:0] a, input logic [31:0] d);
        if (k < log_a0.size()) begin
            check("log_wide_addr", {24'h0, log_a0[k]}, {24'h0, a});
            check("log_wide_data", log_d0[k], d);
        end else begin
            check("log_wide_missing", log_a0.size(), k + 1);
        end
    endtask

    task automatic check_log1(input int k, input logic [7:0] a, input logic [31:0] d);
        if (k < log_a1.size()) begin
            check("log_narrow_addr", {24'h0, log_a1[k]}, {24'h0, a});
            check("log_narrow_data", log_d1[k], d);
        end else begin
            check("log_narrow_missing", log_a1.size(), k + 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, {24'h0, addr0}, 0);
        check({tag, "_ins"},  ins0, 0);
        check({tag, "_ctl"},  {28'h0, wr0, busy0, done0, err0}, 0);
        check({tag, "_ctl_n"}, {28'h0, wr1, busy1, done1, err1}, 0);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        cmp_en = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Ignored inputs: bytes before start, start mid-word
        cyc(0, 1, 8'hAA); cyc(0, 1, 8'hBB); idle(2);
        check("idle_busy", {31'h0, busy0}, 0);
        clear_logs();
        cyc(1, 0, 8'h00);
        check("start_busy", {31'h0, busy0}, 1);
        cyc(0, 1, 8'h12); cyc(0, 1, 8'h34);
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h56); cyc(0, 1, 8'h78);
        idle(2);
        send_word(32'hFFFF_FFFF);
        idle(2);
        check("ign_count", log_a0.size(), 2);
        check_log0(0, 8'd0, 32'h1234_5678);
        check_log0(1, 8'd1, 32'hFFFF_FFFF);

        // Normal load with explicit write timing on the first word
        clear_logs();
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h20); cyc(0, 1, 8'h01); cyc(0, 1, 8'h00); cyc(0, 1, 8'h05);
        check("t_wr_n1",   {31'h0, wr0}, 1);
        check("t_addr_n1", {24'h0, addr0}, 0);
        check("t_ins_n1",  ins0, 32'h2001_0005);
        idle(1);
        check("t_wr_n2",   {31'h0, wr0}, 0);
        check("t_addr_n2", {24'h0, addr0}, 1);
        check("t_busy_n2", {31'h0, busy0}, 1);
        send_word(32'h0000_0000);
        send_word(32'hFFFF_FFFF);
        idle(2);
        check("norm_count", log_a0.size(), 3);
        check_log0(0, 8'd0, 32'h2001_0005);
        check_log0(1, 8'd1, 32'h0000_0000);
        check_log0(2, 8'd2, 32'hFFFF_FFFF);
        check("norm_done", {29'h0, done0, err0, busy0}, 32'b100);
        check("norm_addr", {24'h0, addr0}, 2);
        // Ticks while finished are ignored
        send_word(32'h1111_1111);
        check("done_nowrite", log_a0.size(), 3);

        // Back-to-back ticks: byte 05 lands in the WRITE cycle of the first word
        clear_logs();
        cyc(1, 0, 8'h00);
        for (int k = 1; k <= 8; k++) cyc(0, 1, 8'(k));
        idle(2);
        send_word(32'hFFFF_FFFF);
        idle(2);
        check_log0(0, 8'd0, 32'h0102_0304);
        check_log0(1, 8'd1, 32'h0506_0708);
        check_log0(2, 8'd2, 32'hFFFF_FFFF);

        // Overflow on the narrow instance; the wide one keeps going
        clear_logs();
        cyc(1, 0, 8'h00);
        for (int k = 1; k <= 4; k++) send_word(32'(k));
        idle(2);
        check("ovf_count", log_a1.size(), 4);
        for (int k = 0; k < 4; k++) check_log1(k, 8'(k), 32'(k + 1));
        check("ovf_flags", {29'h0, done1, err1, busy1}, 32'b110);
        check("ovf_wide_busy", {31'h0, busy0}, 1);
        send_word(32'h0000_0005);
        idle(2);
        check("ovf_5th_none", log_a1.size(), 4);
        check_log0(4, 8'd4, 32'h0000_0005);
        send_word(32'hFFFF_FFFF);
        idle(2);

        // Reset mid-word, then a clean load
        clear_logs();
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h20); cyc(0, 1, 8'h01);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("midrst");
        cyc(1, 0, 8'h00);
        send_word(32'hAABB_CCDD);
        send_word(32'hFFFF_FFFF);
        idle(2);
        check("rst_count", log_a0.size(), 2);
        check_log0(0, 8'd0, 32'hAABB_CCDD);
        check_log0(1, 8'd1, 32'hFFFF_FFFF);
        check_log1(0, 8'd0, 32'hAABB_CCDD);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
